serial_parity_tx: RTL

Moore-style serial frame transmitter. It is the sending end of the single-bit serial line that the team's even/odd parity detector FSMs consume. It accepts a parallel word on a start pulse and shifts it out one bit per clock: start bit, data LSB-first, parity bit, stop bit(s). Sits between a parallel producer and the serial checker input (x).

---
 rtl/serial_parity_tx.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/serial_parity_tx.sv
`default_nettype none
// ============================================================================
//  Module   : serial_parity_tx
//  Function : Moore serial frame transmitter (start, LSB-first data, parity,
//             stop). Define TX_STOP2_EN for a frame with two stop bits.
//  Revision : 1.0  initial release
// ============================================================================
module serial_parity_tx #(
   parameter int DATA_W     = 8,
   parameter bit ODD_PARITY = 1'b0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [DATA_W-1:0] data_in,
   output logic              x_out,
   output logic              busy,
   output logic              done
);

   localparam int              CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
`ifdef TX_STOP2_EN
      , S_STOP2 = 3'd5
`endif
   } state_t;

   // The final stop cycle is where done pulses and a new frame may be accepted.
`ifdef TX_STOP2_EN
   localparam state_t S_LAST = S_STOP2;
`else
   localparam state_t S_LAST = S_STOP;
`endif

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   shift_q, shift_d;
   logic [CNT_W-1:0]    cnt_q,   cnt_d;
   logic                par_q,   par_d;
   logic                accept;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         shift_q <= '0;
         cnt_q   <= '0;
         par_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         par_q   <= par_d;
      end
   end

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      par_d   = par_q;
      accept  = start && ((state_q == S_IDLE) || (state_q == S_LAST));

      case (state_q)
         S_IDLE: begin
            state_d = S_IDLE;
         end
         S_START: begin
            state_d = S_DATA;
            cnt_d   = '0;
         end
         S_DATA: begin
            shift_d = shift_q >> 1;
            if (cnt_q == CNT_LAST) begin
               state_d = S_PARITY;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_PARITY: begin
            state_d = S_STOP;
         end
`ifdef TX_STOP2_EN
         S_STOP: begin
            state_d = S_STOP2;
         end
         S_STOP2: begin
            state_d = S_IDLE;
         end
`else
         S_STOP: begin
            state_d = S_IDLE;
         end
`endif
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Accept overrides the normal progression so frames can abut.
      if (accept) begin
         state_d = S_START;
         shift_d = data_in;
         par_d   = (^data_in) ^ ODD_PARITY;
         cnt_d   = '0;
      end
   end

   always_comb begin
      x_out = 1'b1;
      busy  = 1'b0;
      done  = 1'b0;
      case (state_q)
         S_IDLE: begin
            x_out = 1'b1;
            busy  = 1'b0;
         end
         S_START: begin
            x_out = 1'b0;
            busy  = 1'b1;
         end
         S_DATA: begin
            x_out = shift_q[0];
            busy  = 1'b1;
         end
         S_PARITY: begin
            x_out = par_q;
            busy  = 1'b1;
         end
         S_STOP: begin
            x_out = 1'b1;
            busy  = 1'b1;
            done  = (S_LAST == S_STOP);
         end
`ifdef TX_STOP2_EN
         S_STOP2: begin
            x_out = 1'b1;
            busy  = 1'b1;
            done  = 1'b1;
         end
`endif
         default: begin
            x_out = 1'b1;
            busy  = 1'b0;
            done  = 1'b0;
         end
      endcase
   end

endmodule
`default_nettype wire
